lfsr_stream_sink: RTL and testbench
===================================

Name: lfsr_stream_sink

Overview:
Downstream consumer of the LFSR generator's AXI-Stream output (m_axis_tdata/tvalid/tready). Buffers incoming 32-bit LFSR words in a synchronous FIFO with full AXI-Stream backpressure. Keeps a running beat count and a sticky stall flag. Exposes status, a pop-on-read data port and control through its own 4-bit AXI-Lite slave, so software can drain and check the generated sequence.

Parameters:
DATA_W, 32, stream and AXI-Lite data width
DEPTH, 16, FIFO depth in words; power of two, 2..256
CNT_W, $clog2(DEPTH)+1, FIFO occupancy width

Ports:
aclk  in  1  clock; all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  32  LFSR word
s_axis_tvalid  in  1  upstream word valid
s_axis_tready  out  1  sink can accept a word
s_axi_awaddr  in  4  write address
s_axi_awvalid  in  1  write address valid
s_axi_awready  out  1  write address accepted
s_axi_wdata  in  32  write data
s_axi_wvalid  in  1  write data valid
s_axi_wready  out  1  write data accepted
s_axi_bresp  out  2  write response
s_axi_bvalid  out  1  write response valid
s_axi_bready  in  1  master accepts response
s_axi_araddr  in  4  read address
s_axi_arvalid  in  1  read address valid
s_axi_arready  out  1  read address accepted
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  read response
s_axi_rvalid  out  1  read data valid
s_axi_rready  in  1  master accepts read data

Behaviour:
- Reset (aresetn low, asynchronous): all ready/valid outputs 0; bresp, rresp and rdata 0; FIFO empty; TOTAL 0; stall 0; enable 0. Takes effect mid-transaction. In-flight bvalid/rvalid drop, FIFO contents are lost, and no response is owed.
- Register map (awaddr/araddr[3:2]; bits [1:0] ignored):
  - 0x0 STATUS (RO): [0] empty, [1] full, [2] stall sticky, [16+:CNT_W] count.
  - 0x4 DATA (RO, pop-on-read).
  - 0x8 TOTAL (RO): beats accepted; wraps 0xFFFFFFFF->0.
  - 0xC CTRL (RW): [0] enable; [1] clear, write-1 self-clearing, reads 0.
  - Writes to 0x0/0x4/0x8 are ignored and return bresp OKAY.
- Stream side:
  - s_axis_tready = enable && !full, registered from next-state.
  - Beat accepted when tvalid && tready: push the word, TOTAL += 1.
  - Stall sticky sets on any cycle with enable && tvalid && full.
  - Words are never dropped under backpressure.
- Write channel:
  - Idle with awvalid && wvalid both high -> awready=wready=1 for exactly one cycle; the register update happens in that cycle.
  - Next cycle bvalid=1, bresp=00, held until bready.
  - No new write is accepted while bvalid=1.
  - If only one of awvalid/wvalid is high, wait; nothing is accepted.
- Read channel:
  - Idle with arvalid and rvalid=0 -> arready=1 for one cycle.
  - rdata/rresp are registered from state at that cycle; rvalid=1 next cycle, held stable until rready.
  - DATA with FIFO non-empty: returns the head word, pops in the handshake cycle, rresp=00.
  - DATA with FIFO empty: rdata=0, rresp=10 (SLVERR), no pop.
  - Other addresses: rresp=00.
- Read and write channels are independent; both handshakes in one cycle are both served.
- Simultaneous push and pop on a non-empty FIFO: count unchanged, order preserved. Push on an empty FIFO is readable on the next read handshake; no fall-through into the same cycle.
- Clear:
  - Flushes the FIFO and zeroes TOTAL and stall.
  - A stream beat accepted in the clear cycle is discarded and not counted.
  - A DATA read handshake in the clear cycle returns the pre-flush head.
  - Enable takes the written bit[0] in the same write.
- Disable (enable 0): tready falls next cycle; FIFO contents retained and still readable.

Decomposition:
- Package lfsr_sink_pkg:
  - register offsets (REG_STATUS=4'h0, REG_DATA=4'h4, REG_TOTAL=4'h8, REG_CTRL=4'hC)
  - resp codes RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - STATUS bit positions
- Sub-module sync_fifo:
  - parameters DATA_W, DEPTH
  - ports push, pop, flush, din, dout (head), count, full, empty
  - pointer wrap by extra MSB
- AXI-Lite FSMs and counters live in the top module.

Test Plan:
1. Reset, write CTRL=0x1, stream 3 words 0xA5, 0x52, 0x29 -> STATUS count=3, empty=0; three DATA reads return 0xA5, 0x52, 0x29 with rresp=00; fourth DATA read returns 0x0 with rresp=10.
2. Enable, tvalid held high with 20 distinct words, no reads -> tready drops after 16 accepts; STATUS full=1, stall=1, count=16; TOTAL=16; draining 16 reads returns words 1..16 in order, then words 17..20 flow in.
3. FIFO at count=5, DATA read handshake in the same cycle as a stream beat -> count stays 5, next read returns the old second word.
4. FIFO at count=4, TOTAL=4, write CTRL=0x3 while tvalid=1 -> STATUS reads count=0, empty=1, stall=0; TOTAL=0; the beat in the clear cycle is absent; enable stays 1.
5. Assert aresetn low while rvalid=1 and count=8 -> rvalid, tready and awready drop immediately; after release, STATUS=0x00000001 and CTRL reads 0x0.
6. awvalid held high 3 cycles before wvalid, with bready=0 for 4 cycles -> awready/wready pulse once when both are high; bvalid holds with bresp=00 until bready; a second write is not accepted until then.

Source files
------------

// File: rtl/lfsr_sink_pkg.sv
// Shared constants for the LFSR stream sink: register map, response codes,
// STATUS/CTRL bit positions and the AXI-Lite channel state encodings.
package lfsr_sink_pkg;

    localparam logic [3:0] REG_STATUS = 4'h0;
    localparam logic [3:0] REG_DATA   = 4'h4;
    localparam logic [3:0] REG_TOTAL  = 4'h8;
    localparam logic [3:0] REG_CTRL   = 4'hC;

    // Word selectors: only address bits [3:2] pick a register.
    localparam logic [1:0] SEL_STATUS = REG_STATUS[3:2];
    localparam logic [1:0] SEL_DATA   = REG_DATA[3:2];
    localparam logic [1:0] SEL_TOTAL  = REG_TOTAL[3:2];
    localparam logic [1:0] SEL_CTRL   = REG_CTRL[3:2];

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int STATUS_EMPTY_BIT = 0;
    localparam int STATUS_FULL_BIT  = 1;
    localparam int STATUS_STALL_BIT = 2;
    localparam int STATUS_COUNT_LSB = 16;

    localparam int CTRL_ENABLE_BIT = 0;
    localparam int CTRL_CLEAR_BIT  = 1;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_ACK  = 2'd1,
        W_RESP = 2'd2
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE = 2'd0,
        R_ACK  = 2'd1,
        R_RESP = 2'd2
    } rd_state_e;

    // Register word selector from a byte address; the low two bits are ignored.
    function automatic logic [1:0] reg_sel(input logic [3:0] addr);
        return addr[3:2];
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head output. Pointers carry one extra
// MSB so full and empty are distinguished without a separate counter.
module sync_fifo
    import lfsr_sink_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int CNT_W = AW + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW:0]       wr_ptr_r;
    logic [AW:0]       rd_ptr_r;
    logic              do_push_s;
    logic              do_pop_s;

    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign count     = wr_ptr_r - rd_ptr_r;
    assign dout      = mem_r[rd_ptr_r[AW-1:0]];
    assign do_push_s = push && !full && !flush;
    assign do_pop_s  = pop && !empty && !flush;

    // Pointer update; flush returns both pointers to the start.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
        end
    end

    // Storage array; contents need no reset because the pointers gate visibility.
    always_ff @(posedge aclk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= din;
        end
    end

endmodule

// File: rtl/lfsr_stream_sink.sv
// AXI-Stream sink for the LFSR generator: buffers words in a FIFO, counts
// accepted beats, flags backpressure stalls and exposes it all over AXI-Lite.
module lfsr_stream_sink
    import lfsr_sink_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_axis_tdata,
    input  logic              s_axis_tvalid,
    output logic              s_axis_tready,
    input  logic [3:0]        s_axi_awaddr,
    input  logic              s_axi_awvalid,
    output logic              s_axi_awready,
    input  logic [DATA_W-1:0] s_axi_wdata,
    input  logic              s_axi_wvalid,
    output logic              s_axi_wready,
    output logic [1:0]        s_axi_bresp,
    output logic              s_axi_bvalid,
    input  logic              s_axi_bready,
    input  logic [3:0]        s_axi_araddr,
    input  logic              s_axi_arvalid,
    output logic              s_axi_arready,
    output logic [DATA_W-1:0] s_axi_rdata,
    output logic [1:0]        s_axi_rresp,
    output logic              s_axi_rvalid,
    input  logic              s_axi_rready
);

    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [DATA_W-1:0] TOTAL_ONE = {{(DATA_W-1){1'b0}}, 1'b1};

    wr_state_e         w_state_r, w_state_nxt_s;
    rd_state_e         r_state_r, r_state_nxt_s;

    logic              awready_r;
    logic              bvalid_r;
    logic [1:0]        bresp_r;
    logic              arready_r;
    logic              rvalid_r;
    logic [DATA_W-1:0] rdata_r;
    logic [1:0]        rresp_r;
    logic              tready_r;
    logic              enable_r;
    logic              stall_r;
    logic [DATA_W-1:0] total_r;

    logic              wr_fire_s;
    logic              rd_fire_s;
    logic              ctrl_wr_s;
    logic              clear_s;
    logic              enable_nxt_s;
    logic              beat_s;
    logic              push_s;
    logic              pop_s;
    logic [CNT_W-1:0]  cnt_nxt_s;
    logic [DATA_W-1:0] fifo_dout_s;
    logic [CNT_W-1:0]  count_s;
    logic              full_s;
    logic              empty_s;
    logic [DATA_W-1:0] status_s;
    logic [DATA_W-1:0] ctrl_s;
    logic [DATA_W-1:0] rd_data_s;
    logic [1:0]        rd_resp_s;
    logic              unused_s;

    assign s_axis_tready = tready_r;
    assign s_axi_awready = awready_r;
    assign s_axi_wready  = awready_r;
    assign s_axi_bvalid  = bvalid_r;
    assign s_axi_bresp   = bresp_r;
    assign s_axi_arready = arready_r;
    assign s_axi_rvalid  = rvalid_r;
    assign s_axi_rdata   = rdata_r;
    assign s_axi_rresp   = rresp_r;

    // Address low bits and upper CTRL data bits carry no meaning here.
    assign unused_s = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0], s_axi_wdata[DATA_W-1:2]};

    // The ACK states are the cycles in which the AXI-Lite handshakes complete.
    assign wr_fire_s = (w_state_r == W_ACK);
    assign rd_fire_s = (r_state_r == R_ACK);
    assign ctrl_wr_s = wr_fire_s && (reg_sel(s_axi_awaddr) == SEL_CTRL);
    assign clear_s   = ctrl_wr_s && s_axi_wdata[CTRL_CLEAR_BIT];
    assign beat_s    = s_axis_tvalid && tready_r;
    assign push_s    = beat_s && !clear_s;
    assign pop_s     = rd_fire_s && (reg_sel(s_axi_araddr) == SEL_DATA) && !empty_s;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .aclk    (aclk),
        .aresetn (aresetn),
        .push    (push_s),
        .pop     (pop_s),
        .flush   (clear_s),
        .din     (s_axis_tdata),
        .dout    (fifo_dout_s),
        .count   (count_s),
        .full    (full_s),
        .empty   (empty_s)
    );

    // Next enable and next FIFO occupancy, used to register tready ahead of time.
    always_comb begin
        enable_nxt_s = enable_r;
        cnt_nxt_s    = count_s;
        if (ctrl_wr_s) begin
            enable_nxt_s = s_axi_wdata[CTRL_ENABLE_BIT];
        end else begin
            enable_nxt_s = enable_r;
        end
        if (clear_s) begin
            cnt_nxt_s = '0;
        end else if (push_s && !pop_s) begin
            cnt_nxt_s = count_s + CNT_ONE;
        end else if (pop_s && !push_s) begin
            cnt_nxt_s = count_s - CNT_ONE;
        end else begin
            cnt_nxt_s = count_s;
        end
    end

    // Stream-side state: enable, registered tready, beat total and sticky stall.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            enable_r <= 1'b0;
            tready_r <= 1'b0;
            total_r  <= '0;
            stall_r  <= 1'b0;
        end else begin
            enable_r <= enable_nxt_s;
            tready_r <= enable_nxt_s && (cnt_nxt_s != DEPTH_CNT);
            if (clear_s) begin
                total_r <= '0;
                stall_r <= 1'b0;
            end else begin
                if (beat_s) begin
                    total_r <= total_r + TOTAL_ONE;
                end
                if (enable_r && s_axis_tvalid && full_s) begin
                    stall_r <= 1'b1;
                end
            end
        end
    end

    // Write channel next-state: accept only when address and data arrive together.
    always_comb begin
        w_state_nxt_s = w_state_r;
        case (w_state_r)
            W_IDLE: begin
                if (s_axi_awvalid && s_axi_wvalid) begin
                    w_state_nxt_s = W_ACK;
                end else begin
                    w_state_nxt_s = W_IDLE;
                end
            end
            W_ACK: begin
                w_state_nxt_s = W_RESP;
            end
            W_RESP: begin
                if (s_axi_bready) begin
                    w_state_nxt_s = W_IDLE;
                end else begin
                    w_state_nxt_s = W_RESP;
                end
            end
            default: begin
                w_state_nxt_s = W_IDLE;
            end
        endcase
    end

    // Write channel state and its registered handshake outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            w_state_r <= W_IDLE;
            awready_r <= 1'b0;
            bvalid_r  <= 1'b0;
            bresp_r   <= RESP_OKAY;
        end else begin
            w_state_r <= w_state_nxt_s;
            awready_r <= (w_state_nxt_s == W_ACK);
            bvalid_r  <= (w_state_nxt_s == W_RESP);
            if (wr_fire_s) begin
                bresp_r <= RESP_OKAY;
            end
        end
    end

    // Read channel next-state: one address accepted per outstanding response.
    always_comb begin
        r_state_nxt_s = r_state_r;
        case (r_state_r)
            R_IDLE: begin
                if (s_axi_arvalid && !rvalid_r) begin
                    r_state_nxt_s = R_ACK;
                end else begin
                    r_state_nxt_s = R_IDLE;
                end
            end
            R_ACK: begin
                r_state_nxt_s = R_RESP;
            end
            R_RESP: begin
                if (s_axi_rready) begin
                    r_state_nxt_s = R_IDLE;
                end else begin
                    r_state_nxt_s = R_RESP;
                end
            end
            default: begin
                r_state_nxt_s = R_IDLE;
            end
        endcase
    end

    // Readback mux evaluated against the state seen in the address handshake cycle.
    always_comb begin
        status_s                                  = '0;
        status_s[STATUS_EMPTY_BIT]                = empty_s;
        status_s[STATUS_FULL_BIT]                 = full_s;
        status_s[STATUS_STALL_BIT]                = stall_r;
        status_s[STATUS_COUNT_LSB +: CNT_W]       = count_s;
        ctrl_s                                    = '0;
        ctrl_s[CTRL_ENABLE_BIT]                   = enable_r;
        rd_data_s                                 = '0;
        rd_resp_s                                 = RESP_OKAY;
        case (reg_sel(s_axi_araddr))
            SEL_STATUS: rd_data_s = status_s;
            SEL_DATA: begin
                if (!empty_s) begin
                    rd_data_s = fifo_dout_s;
                    rd_resp_s = RESP_OKAY;
                end else begin
                    rd_data_s = '0;
                    rd_resp_s = RESP_SLVERR;
                end
            end
            SEL_TOTAL:  rd_data_s = total_r;
            SEL_CTRL:   rd_data_s = ctrl_s;
            default:    rd_data_s = '0;
        endcase
    end

    // Read channel state, handshake outputs and response capture.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state_r <= R_IDLE;
            arready_r <= 1'b0;
            rvalid_r  <= 1'b0;
            rdata_r   <= '0;
            rresp_r   <= RESP_OKAY;
        end else begin
            r_state_r <= r_state_nxt_s;
            arready_r <= (r_state_nxt_s == R_ACK);
            rvalid_r  <= (r_state_nxt_s == R_RESP);
            if (rd_fire_s) begin
                rdata_r <= rd_data_s;
                rresp_r <= rd_resp_s;
            end
        end
    end

endmodule

// File: tb/tb_lfsr_stream_sink.sv
// Self-checking bench for lfsr_stream_sink. A queue-based reference model of
// the FIFO, beat total, stall flag and enable predicts every readback.
module tb_lfsr_stream_sink;

    localparam int DEPTH = 16;

    logic        aclk;
    logic        aresetn;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic [3:0]  s_axi_awaddr;
    logic        s_axi_awvalid;
    logic        s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic        s_axi_wvalid;
    logic        s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid;
    logic        s_axi_bready;
    logic [3:0]  s_axi_araddr;
    logic        s_axi_arvalid;
    logic        s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid;
    logic        s_axi_rready;

    lfsr_stream_sink dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int          checks   = 0;
    int          failures = 0;

    // Reference model and stream source
    logic [31:0] src_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] exp_total;
    bit          exp_en;
    bit          exp_stall;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_rresp;
    bit          hs_rd;
    bit          hs_wr;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        src_q.delete();
        exp_total = 32'd0;
        exp_en    = 1'b0;
        exp_stall = 1'b0;
    endtask

    // One clock cycle, called at a falling edge: drive the stream source, check
    // tready, apply the spec rules for the coming rising edge, then advance.
    task automatic step();
        int  sz;
        bit  beat;
        bit  clr;
        bit  full_pre;
        if (src_q.size() > 0) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = src_q[0];
        end else begin
            s_axis_tvalid = 1'b0;
            s_axis_tdata  = 32'd0;
        end
        sz       = exp_q.size();
        full_pre = (sz == DEPTH);
        chk("tready", {31'd0, s_axis_tready}, {31'd0, (exp_en && !full_pre)});
        beat  = s_axis_tvalid && s_axis_tready;
        hs_rd = s_axi_arvalid && s_axi_arready;
        hs_wr = s_axi_awvalid && s_axi_awready && s_axi_wvalid && s_axi_wready;
        clr   = 1'b0;
        if (hs_rd) begin
            exp_rresp = 2'b00;
            exp_rdata = 32'd0;
            case (s_axi_araddr[3:2])
                2'd0: begin
                    exp_rdata[20:16] = 5'(sz);
                    exp_rdata[2]     = exp_stall;
                    exp_rdata[1]     = full_pre;
                    exp_rdata[0]     = (sz == 0);
                end
                2'd1: begin
                    if (sz > 0) exp_rdata = exp_q.pop_front();
                    else exp_rresp = 2'b10;
                end
                2'd2: exp_rdata = exp_total;
                default: exp_rdata[0] = exp_en;
            endcase
        end
        if (exp_en && s_axis_tvalid && full_pre) exp_stall = 1'b1;
        if (hs_wr && s_axi_awaddr[3:2] == 2'd3) begin
            clr    = s_axi_wdata[1];
            exp_en = s_axi_wdata[0];
        end
        if (clr) begin
            exp_q.delete();
            exp_total = 32'd0;
            exp_stall = 1'b0;
        end else if (beat) begin
            exp_q.push_back(s_axis_tdata);
            exp_total = exp_total + 32'd1;
        end
        if (beat) void'(src_q.pop_front());
        @(posedge aclk);
        @(negedge aclk);
    endtask

    task automatic axil_read(input logic [3:0] addr, input bit beat_at_hs, input bit hold);
        int n = 0;
        s_axi_araddr  = addr;
        s_axi_arvalid = 1'b1;
        hs_rd         = 1'b0;
        while (!hs_rd && n < 20) begin
            if (beat_at_hs && s_axi_arready) src_q.push_back($urandom);
            step();
            n++;
        end
        s_axi_arvalid = 1'b0;
        chk("ar_handshake", {31'd0, hs_rd}, 32'd1);
        chk("rvalid_set", {31'd0, s_axi_rvalid}, 32'd1);
        chk("rdata", s_axi_rdata, exp_rdata);
        chk("rresp", {30'd0, s_axi_rresp}, {30'd0, exp_rresp});
        if (!hold) begin
            step();
            chk("rvalid_clear", {31'd0, s_axi_rvalid}, 32'd0);
        end
    endtask

    task automatic axil_write(input logic [3:0] addr, input logic [31:0] data, input bit beat_at_hs);
        int n = 0;
        s_axi_awaddr  = addr;
        s_axi_wdata   = data;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b1;
        hs_wr         = 1'b0;
        while (!hs_wr && n < 20) begin
            if (beat_at_hs && s_axi_awready) src_q.push_back($urandom);
            step();
            n++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        chk("aw_handshake", {31'd0, hs_wr}, 32'd1);
        chk("bvalid_set", {31'd0, s_axi_bvalid}, 32'd1);
        chk("bresp", {30'd0, s_axi_bresp}, 32'd0);
        step();
        chk("bvalid_clear", {31'd0, s_axi_bvalid}, 32'd0);
    endtask

    task automatic drain_src();
        int n = 0;
        while (src_q.size() > 0 && n < 60) begin
            step();
            n++;
        end
        chk("src_drain", 32'(src_q.size()), 32'd0);
    endtask

    initial begin
        int pulses;
        logic [3:0] a;
        s_axis_tdata  = 32'd0;
        s_axis_tvalid = 1'b0;
        s_axi_awaddr  = 4'd0;
        s_axi_awvalid = 1'b0;
        s_axi_wdata   = 32'd0;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b1;
        s_axi_araddr  = 4'd0;
        s_axi_arvalid = 1'b0;
        s_axi_rready  = 1'b1;
        aresetn       = 1'b0;
        model_reset();
        #2;
        chk("rst_tready",  {31'd0, s_axis_tready}, 32'd0);
        chk("rst_awready", {31'd0, s_axi_awready}, 32'd0);
        chk("rst_wready",  {31'd0, s_axi_wready},  32'd0);
        chk("rst_bvalid",  {31'd0, s_axi_bvalid},  32'd0);
        chk("rst_arready", {31'd0, s_axi_arready}, 32'd0);
        chk("rst_rvalid",  {31'd0, s_axi_rvalid},  32'd0);
        chk("rst_bresp",   {30'd0, s_axi_bresp},   32'd0);
        chk("rst_rresp",   {30'd0, s_axi_rresp},   32'd0);
        chk("rst_rdata",   s_axi_rdata,            32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        step();

        // 1: three known words, drained in order, then an empty-FIFO error read
        axil_write(4'hC, 32'h1, 1'b0);
        src_q.push_back(32'hA5);
        src_q.push_back(32'h52);
        src_q.push_back(32'h29);
        drain_src();
        axil_read(4'h0, 1'b0, 1'b0);
        chk("t1_status", s_axi_rdata, 32'h0003_0000);
        repeat (4) axil_read(4'h4, 1'b0, 1'b0);
        chk("t1_empty_rresp", {30'd0, s_axi_rresp}, 32'd2);

        // 2: overfill with 20 distinct words, then drain everything
        axil_write(4'hC, 32'h3, 1'b0);
        for (int i = 1; i <= 20; i++) src_q.push_back(32'h1000_0000 + 32'(i));
        repeat (24) step();
        axil_read(4'h0, 1'b0, 1'b0);
        chk("t2_status_full", s_axi_rdata, 32'h0010_0006);
        axil_read(4'h8, 1'b0, 1'b0);
        chk("t2_total", s_axi_rdata, 32'd16);
        repeat (16) axil_read(4'h4, 1'b0, 1'b0);
        drain_src();
        axil_read(4'h0, 1'b0, 1'b0);
        repeat (5) axil_read(4'h4, 1'b0, 1'b0);

        // 3: pop and push in the same cycle at count 5
        axil_write(4'hC, 32'h3, 1'b0);
        repeat (5) src_q.push_back($urandom);
        drain_src();
        axil_read(4'h4, 1'b1, 1'b0);
        axil_read(4'h0, 1'b0, 1'b0);
        chk("t3_count", s_axi_rdata, 32'h0005_0000);
        axil_read(4'h4, 1'b0, 1'b0);

        // 4: clear with a beat in the clear cycle
        axil_write(4'hC, 32'h3, 1'b0);
        repeat (4) src_q.push_back($urandom);
        drain_src();
        axil_read(4'h8, 1'b0, 1'b0);
        axil_write(4'hC, 32'h3, 1'b1);
        axil_read(4'h0, 1'b0, 1'b0);
        chk("t4_status", s_axi_rdata, 32'h0000_0001);
        axil_read(4'h8, 1'b0, 1'b0);
        axil_read(4'hC, 1'b0, 1'b0);
        src_q.push_back($urandom);
        drain_src();
        axil_read(4'h4, 1'b0, 1'b0);

        // Randomized mix of stream beats, reads of any address and writes
        for (int it = 0; it < 60; it++) begin
            case ($urandom_range(0, 5))
                0, 1: repeat ($urandom_range(1, 3)) src_q.push_back($urandom);
                2: begin
                    a = 4'($urandom_range(0, 15));
                    axil_read(a, 1'b0, 1'b0);
                end
                3, 4: axil_read(4'h4 | 4'($urandom_range(0, 3)), 1'b0, 1'b0);
                default: begin
                    if ($urandom_range(0, 2) != 0) begin
                        axil_write(4'hC, {30'd0, ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)}, 1'b0);
                    end else begin
                        axil_write(4'($urandom_range(0, 2) * 4), $urandom, 1'b0);
                    end
                end
            endcase
            step();
        end
        src_q.delete();

        // 5: asynchronous reset with a response pending and data buffered
        axil_write(4'hC, 32'h3, 1'b0);
        repeat (9) src_q.push_back($urandom);
        drain_src();
        s_axi_rready = 1'b0;
        axil_read(4'h4, 1'b0, 1'b1);
        step();
        chk("t5_rvalid_held", {31'd0, s_axi_rvalid}, 32'd1);
        chk("t5_rdata_held", s_axi_rdata, exp_rdata);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t5_rvalid_drop",  {31'd0, s_axi_rvalid},  32'd0);
        chk("t5_tready_drop",  {31'd0, s_axis_tready}, 32'd0);
        chk("t5_awready_drop", {31'd0, s_axi_awready}, 32'd0);
        chk("t5_rdata_zero",   s_axi_rdata,            32'd0);
        model_reset();
        s_axis_tvalid = 1'b0;
        s_axi_rready  = 1'b1;
        @(negedge aclk);
        aresetn = 1'b1;
        step();
        axil_read(4'h0, 1'b0, 1'b0);
        chk("t5_status", s_axi_rdata, 32'h0000_0001);
        axil_read(4'hC, 1'b0, 1'b0);
        chk("t5_ctrl", s_axi_rdata, 32'h0);

        // 6: address before data, response held under bready low
        s_axi_awaddr  = 4'hC;
        s_axi_wdata   = 32'h1;
        s_axi_awvalid = 1'b1;
        s_axi_wvalid  = 1'b0;
        s_axi_bready  = 1'b0;
        repeat (3) begin
            step();
            chk("t6_no_awready", {31'd0, s_axi_awready}, 32'd0);
        end
        s_axi_wvalid = 1'b1;
        pulses = 0;
        hs_wr  = 1'b0;
        for (int n = 0; n < 10 && !hs_wr; n++) begin
            if (s_axi_awready) pulses++;
            step();
        end
        chk("t6_pulses", 32'(pulses), 32'd1);
        chk("t6_awready_low", {31'd0, s_axi_awready}, 32'd0);
        chk("t6_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        chk("t6_bresp", {30'd0, s_axi_bresp}, 32'd0);
        s_axi_wdata = 32'h0;
        repeat (4) begin
            step();
            chk("t6_bvalid_hold", {31'd0, s_axi_bvalid}, 32'd1);
            chk("t6_blocked", {31'd0, s_axi_awready}, 32'd0);
        end
        s_axi_bready = 1'b1;
        step();
        chk("t6_bvalid_done", {31'd0, s_axi_bvalid}, 32'd0);
        axil_write(4'hC, 32'h0, 1'b0);
        axil_read(4'hC, 1'b0, 1'b0);
        chk("t6_ctrl", s_axi_rdata, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
